chunked_serial_subtractor: RTL and testbench

Multi-cycle subtractor: diff = a - b - borrow_in, computed CHUNK bits per cycle with a registered borrow chain.
- Area-lean counterpart to the team's combinational adders, for the npc datapath (compare/branch and ALU sub paths that tolerate latency).
- Valid/ready handshake on input and output.
- Produces difference, borrow-out, zero and signed-overflow flags.

---
 rtl/chunked_serial_subtractor_pkg.sv | 20 ++
 rtl/chunked_serial_subtractor_sub_chunk.sv | 16 +
 rtl/chunked_serial_subtractor.sv | 138 +++++++++++++
 tb/tb_chunked_serial_subtractor.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/chunked_serial_subtractor_pkg.sv
// Shared types and constants for the chunked serial subtractor.
package chunked_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_NBIT  = 32;
  localparam int DEFAULT_CHUNK = 8;

  // Width of the chunk index counter; never narrower than one bit.
  function automatic int idx_width(input int nchunk);
    int w;
    w = $clog2(nchunk);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/chunked_serial_subtractor_sub_chunk.sv
// One CHUNK-bit slice of the subtractor: {bout, diff} = a - b - bin.
// Done in (W+1)-bit arithmetic; the extra top bit is set exactly when the
// slice result went negative, which is the borrow into the next slice.
module sub_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic [W-1:0] diff,
  output logic         bout
);

  assign {bout, diff} = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};

endmodule

// File: rtl/chunked_serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - borrow_in, CHUNK bits per cycle
// with a registered borrow between slices. Valid/ready on both sides.
// Optional feature macro: CHUNKED_SUB_BACK_TO_BACK_EN lets DONE accept new
// operands in the same cycle the result is taken (DONE -> RUN directly).
module chunked_serial_subtractor
  import chunked_sub_pkg::*;
#(
  parameter int NBIT  = DEFAULT_NBIT,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [NBIT-1:0] a,
  input  logic [NBIT-1:0] b,
  input  logic            borrow_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [NBIT-1:0] diff,
  output logic            borrow_out,
  output logic            zero,
  output logic            ovf
);

  localparam int NCHUNK = NBIT / CHUNK;
  localparam int IW     = idx_width(NCHUNK);

  if ((CHUNK < 1) || (CHUNK > NBIT) || ((NBIT % CHUNK) != 0)) begin : g_bad_params
    $error("chunked_serial_subtractor: NBIT must be a positive multiple of CHUNK");
  end

  state_t            state, state_next;
  logic [NBIT-1:0]   a_q, b_q;
  logic              borrow;
  logic [IW-1:0]     idx;
  logic              in_ready_q, out_valid_q;
  logic [CHUNK-1:0]  a_k, b_k, chunk_diff;
  logic              chunk_bout;
  logic [NBIT-1:0]   diff_next;
  logic              last;
  logic              accept;

  // Operand slice for the current chunk, selected by the index.
  assign a_k  = a_q[idx*CHUNK +: CHUNK];
  assign b_k  = b_q[idx*CHUNK +: CHUNK];
  assign last = (idx == IW'(NCHUNK - 1));

  sub_chunk #(.W(CHUNK)) u_sub_chunk (
    .a    (a_k),
    .b    (b_k),
    .bin  (borrow),
    .diff (chunk_diff),
    .bout (chunk_bout)
  );

`ifdef CHUNKED_SUB_BACK_TO_BACK_EN
  assign in_ready = in_ready_q | ((state == DONE) & out_ready);
`else
  assign in_ready = in_ready_q;
`endif
  assign out_valid = out_valid_q;
  assign accept    = in_valid & in_ready;

  // Full difference with the current chunk merged in, used for final flags.
  always_comb begin
    diff_next = diff;
    diff_next[idx*CHUNK +: CHUNK] = chunk_diff;
  end

  // Next-state logic for the IDLE/RUN/DONE controller.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) state_next = RUN;
        else        state_next = IDLE;
      end
      RUN: begin
        if (last) state_next = DONE;
        else      state_next = RUN;
      end
      DONE: begin
        if (out_ready) begin
          if (accept) state_next = RUN;
          else        state_next = IDLE;
        end else begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register plus registered handshake outputs decoded from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_next;
      in_ready_q  <= (state_next == IDLE);
      out_valid_q <= (state_next == DONE);
    end
  end

  // Operand capture, per-chunk difference and borrow chain, final flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= {NBIT{1'b0}};
      b_q        <= {NBIT{1'b0}};
      borrow     <= 1'b0;
      idx        <= {IW{1'b0}};
      diff       <= {NBIT{1'b0}};
      borrow_out <= 1'b0;
      zero       <= 1'b0;
      ovf        <= 1'b0;
    end else if (((state == IDLE) || (state == DONE)) && accept) begin
      a_q    <= a;
      b_q    <= b;
      borrow <= borrow_in;
      idx    <= {IW{1'b0}};
    end else if (state == RUN) begin
      diff   <= diff_next;
      borrow <= chunk_bout;
      if (last) begin
        idx        <= {IW{1'b0}};
        borrow_out <= chunk_bout;
        zero       <= (diff_next == {NBIT{1'b0}});
        ovf        <= (a_q[NBIT-1] != b_q[NBIT-1]) && (diff_next[NBIT-1] != a_q[NBIT-1]);
      end else begin
        idx <= idx + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_chunked_serial_subtractor.sv
// Scoreboard bench for chunked_serial_subtractor (NBIT=32, CHUNK=8).
module tb_chunked_serial_subtractor;

  localparam int NBIT  = 32;
  localparam int CHUNK = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic            borrow_in = 1'b0;
  logic [NBIT-1:0] a = 32'd0;
  logic [NBIT-1:0] b = 32'd0;
  logic            in_ready, out_valid, borrow_out, zero, ovf;
  logic [NBIT-1:0] diff;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  bit rand_phase = 1'b0;
  logic [34:0] expq[$];

  chunked_serial_subtractor #(.NBIT(NBIT), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .borrow_in(borrow_in), .out_valid(out_valid),
    .out_ready(out_ready), .diff(diff), .borrow_out(borrow_out),
    .zero(zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [34:0] pk(input logic [31:0] d, input logic bo, input logic z, input logic o);
    return {d, bo, z, o};
  endfunction

  // Reference: 33-bit subtraction, flags derived from operand/result signs.
  function automatic logic [34:0] model(input logic [31:0] av, input logic [31:0] bv, input logic bi);
    logic [32:0] t;
    logic o;
    t = {1'b0, av} - {1'b0, bv} - {32'd0, bi};
    o = (av[31] != bv[31]) && (t[31] != av[31]);
    return {t[31:0], t[32], (t[31:0] == 32'd0), o};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present operands until accepted; push the expected result on acceptance.
  task automatic issue(input logic [31:0] av, input logic [31:0] bv, input logic bi, input logic [34:0] e);
    a = av;
    b = bv;
    borrow_in = bi;
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin
        expq.push_back(e);
        acc_cyc = cyc + 1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    total++;
    bad++;
    $display("FAIL accept_timeout: got no accept expected accept within 300 cycles");
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400; i++) begin
      if (expq.size() == 0) return;
      @(posedge clk);
      #1;
    end
    total++;
    bad++;
    $display("FAIL drain_timeout: got %0d pending results expected 0", expq.size());
  endtask

  // Monitor: compare every result the DUT hands over against the scoreboard.
  always @(negedge clk) begin
    logic [34:0] e;
    if (rst_n && out_valid && out_ready) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got %h expected no result", {diff, borrow_out, zero, ovf});
      end else begin
        e = expq.pop_front();
        check("result", 64'({diff, borrow_out, zero, ovf}), 64'(e));
      end
    end
  end

  // Random backpressure during the stream phase.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_phase) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] corners [4];
    logic [31:0] ra, rb;
    logic        rbi;
    int          first;
    corners[0] = 32'h0000_0000;
    corners[1] = 32'hFFFF_FFFF;
    corners[2] = 32'h8000_0000;
    corners[3] = 32'h7FFF_FFFF;

    // Reset values
    #12;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_outputs", 64'({diff, borrow_out, zero, ovf}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: basic subtract and latency
    out_ready = 1'b1;
    issue(32'd5, 32'd3, 1'b0, pk(32'h0000_0002, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 20; i++) begin
      if (out_valid) break;
      @(posedge clk);
      #1;
    end
    check("latency", 64'(cyc - acc_cyc), 64'd4);
    wait_drain();

    // 2: underflow, with and without borrow_in
    issue(32'd0, 32'd1, 1'b0, pk(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0));
    wait_drain();
    issue(32'd0, 32'd1, 1'b1, pk(32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0));
    wait_drain();

    // 3: signed overflow, then zero result
    issue(32'h8000_0000, 32'd1, 1'b0, pk(32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1));
    wait_drain();
    issue(32'h1234_5678, 32'h1234_5678, 1'b0, pk(32'h0000_0000, 1'b0, 1'b1, 1'b0));
    wait_drain();

    // 4: backpressure in DONE
    out_ready = 1'b0;
    issue(32'h0000_00FF, 32'h0000_0001, 1'b0, pk(32'h0000_00FE, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 20; i++) begin
      if (out_valid) break;
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 10; i++) begin
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_diff", 64'(diff), 64'h0000_00FE);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_valid", 64'(out_valid), 64'd0);
    check("release_in_ready", 64'(in_ready), 64'd1);
    wait_drain();

    // 5: asynchronous reset mid-operation, then a clean operation
    issue(32'd0, 32'd1, 1'b0, pk(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0));
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_diff", 64'(diff), 64'd0);
    expq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(32'd10, 32'd4, 1'b0, pk(32'h0000_0006, 1'b0, 1'b0, 1'b0));
    wait_drain();

    // Issue interval with continuous demand and an always-ready consumer
    issue(32'd100, 32'd1, 1'b0, pk(32'd99, 1'b0, 1'b0, 1'b0));
    first = acc_cyc;
    issue(32'd7, 32'd7, 1'b1, pk(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0));
`ifdef CHUNKED_SUB_BACK_TO_BACK_EN
    check("issue_interval", 64'(acc_cyc - first), 64'd5);
`else
    check("issue_interval", 64'(acc_cyc - first), 64'd6);
`endif
    wait_drain();

    // 6: random stream with random gaps and backpressure
    rand_phase = 1'b1;
    for (int n = 0; n < 300; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk);
        #1;
      end
      ra  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : 32'($urandom);
      rb  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : 32'($urandom);
      rbi = 1'($urandom_range(0, 1));
      issue(ra, rb, rbi, model(ra, rb, rbi));
    end
    wait_drain();
    rand_phase = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
